// File: rtl/decoder_pkg.sv
// Shared constants for the sequencing instruction decoder: opcode classes,
// ALU codes, packed control vectors, memory-section Ctrl words and beat FSM states.
package decoder_pkg;

    localparam logic [2:0] OP_DP  = 3'b000;
    localparam logic [2:0] OP_MEM = 3'b001;
    localparam logic [2:0] OP_BR  = 3'b010;
    localparam logic [2:0] OP_KRD = 3'b100;
    localparam logic [2:0] OP_PRD = 3'b101;
    localparam logic [2:0] OP_PST = 3'b110;

    localparam logic [3:0] ALU_VSUM   = 4'b0000;
    localparam logic [3:0] ALU_DOT    = 4'b0001;
    localparam logic [3:0] ALU_SUB    = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0011;
    localparam logic [3:0] ALU_CMP    = 4'b0100;
    localparam logic [3:0] ALU_SCALE  = 4'b0101;
    localparam logic [3:0] ALU_MUL    = 4'b0110;
    localparam logic [3:0] ALU_CONCAT = 4'b0111;

    // Control vector layout: {RegSrc[1:0], ImmSrc[1:0], ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, ALUOp}
    localparam int CV_ALUOP    = 0;
    localparam int CV_BRANCH   = 1;
    localparam int CV_MEMWRITE = 2;
    localparam int CV_REGWRITE = 3;
    localparam int CV_MEMTOREG = 4;
    localparam int CV_ALUSRC   = 5;

    localparam logic [9:0] CV_DP_IMM = 10'b0000101001;
    localparam logic [9:0] CV_DP_REG = 10'b0000001001;
    localparam logic [9:0] CV_LDR    = 10'b0001111000;
    localparam logic [9:0] CV_STR    = 10'b1001110100;
    localparam logic [9:0] CV_BR     = 10'b0010100010;
    localparam logic [9:0] CV_KRD    = 10'b0000011001;
    localparam logic [9:0] CV_PRD    = 10'b1000100101;
    localparam logic [9:0] CV_PST    = 10'b0000011001;

    localparam logic [6:0] CTRL_KRD_F1 = 7'b1101010;
    localparam logic [6:0] CTRL_KRD_F0 = 7'b1100010;
    localparam logic [6:0] CTRL_PRD    = 7'b0100001;
    localparam logic [6:0] CTRL_PST    = 7'b1001110;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } beat_state_t;

endpackage

// File: rtl/decode_beat_fsm.sv
// Beat sequencer for multi-beat memory instructions: tracks the current beat,
// stalls fetch/decode until the final beat, and honours hold/flush.
module decode_beat_fsm
    import decoder_pkg::*;
#(
    parameter int BEAT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic              hold,
    input  logic              flush,
    input  logic [BEAT_W-1:0] n_beats,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              stall,
    output logic              last_beat
);

    beat_state_t       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] last_idx;
    logic              multi;

    always_comb begin
        last_idx = n_beats - BEAT_W'(1);
        multi    = n_beats > BEAT_W'(1);
        state_d  = state_q;
        beat_d   = beat_q;
        if (flush) begin
            state_d = IDLE;
            beat_d  = '0;
        end else if (!hold) begin
            case (state_q)
                IDLE: begin
                    if (instr_valid && multi) begin
                        state_d = SEQ;
                        beat_d  = BEAT_W'(1);
                    end
                end
                SEQ: begin
                    if (beat_q == last_idx) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Stall is combinational so it covers beat 0 of a fresh instruction; reset kills it at once.
    assign beat_idx  = beat_q;
    assign stall     = !reset && instr_valid && multi && (beat_q != last_idx) && !flush;
    assign last_beat = instr_valid && (beat_q == last_idx);

endmodule

// File: rtl/decoder_seq.sv
// Decode-stage instruction decoder: combinational control tables plus expansion
// of kernel/pixel memory instructions into multi-beat sequences.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int KERNEL_BEATS = 9,
    parameter int PIXEL_BEATS  = 4,
    parameter int BEAT_W       = $clog2(((KERNEL_BEATS > PIXEL_BEATS) ? KERNEL_BEATS : PIXEL_BEATS) + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InstrValidD,
    input  logic              HoldD,
    input  logic              FlushD,
    input  logic [2:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [4:0]        Rd,
    output logic [1:0]        FlagWriteD,
    output logic              PCSrcD,
    output logic              RegWriteD,
    output logic              MemWriteD,
    output logic              MemtoRegD,
    output logic              ALUSrcD,
    output logic              BranchD,
    output logic [1:0]        ImmSrcD,
    output logic [1:0]        RegSrc,
    output logic [3:0]        ALUControlD,
    output logic [6:0]        Ctrl,
    output logic [BEAT_W-1:0] BeatIdx,
    output logic              LastBeatD,
    output logic              StallD,
    output logic              IllegalD
);

    logic [9:0]        cv;
    logic [6:0]        ctrl_raw;
    logic [3:0]        alu_raw;
    logic [1:0]        flag_raw;
    logic              illegal;
    logic [BEAT_W-1:0] n_beats;

    always_comb begin
        cv       = '0;
        ctrl_raw = '0;
        alu_raw  = ALU_ADD;
        flag_raw = '0;
        illegal  = 1'b0;
        n_beats  = BEAT_W'(1);
        case (Op)
            OP_DP:  cv = Funct[5] ? CV_DP_IMM : CV_DP_REG;
            OP_MEM: cv = Funct[0] ? CV_LDR : CV_STR;
            OP_BR:  cv = CV_BR;
            OP_KRD: begin
                cv       = CV_KRD;
                ctrl_raw = Funct[0] ? CTRL_KRD_F1 : CTRL_KRD_F0;
                n_beats  = BEAT_W'(KERNEL_BEATS);
            end
            OP_PRD: begin
                cv       = CV_PRD;
                ctrl_raw = CTRL_PRD;
                n_beats  = BEAT_W'(PIXEL_BEATS);
            end
            OP_PST: begin
                cv       = CV_PST;
                ctrl_raw = CTRL_PST;
                n_beats  = BEAT_W'(PIXEL_BEATS);
            end
            default: illegal = 1'b1;
        endcase

        if (cv[CV_ALUOP]) begin
            case (Funct[4:1])
                4'b0000: alu_raw = ALU_VSUM;
                4'b0001: alu_raw = ALU_MUL;
                4'b0010: alu_raw = ALU_SUB;
                4'b0011: alu_raw = ALU_CONCAT;
                4'b0100: alu_raw = ALU_ADD;
                4'b1100: alu_raw = ALU_SCALE;
                4'b1101: alu_raw = ALU_DOT;
                4'b1111: alu_raw = ALU_CMP;
                default: illegal = 1'b1;
            endcase
            flag_raw = {Funct[0], Funct[0] & ((alu_raw == ALU_ADD) || (alu_raw == ALU_SUB))};
        end

        // An illegal instruction is nullified entirely and never starts a sequence.
        if (illegal) begin
            cv       = '0;
            ctrl_raw = '0;
            alu_raw  = '0;
            flag_raw = '0;
            n_beats  = BEAT_W'(1);
        end
    end

    always_comb begin
        FlagWriteD  = '0;
        RegWriteD   = 1'b0;
        MemWriteD   = 1'b0;
        MemtoRegD   = 1'b0;
        ALUSrcD     = 1'b0;
        BranchD     = 1'b0;
        ImmSrcD     = '0;
        RegSrc      = '0;
        ALUControlD = '0;
        Ctrl        = '0;
        IllegalD    = 1'b0;
        PCSrcD      = 1'b0;
        if (InstrValidD) begin
            MemtoRegD   = cv[CV_MEMTOREG];
            ALUSrcD     = cv[CV_ALUSRC];
            ImmSrcD     = cv[7:6];
            RegSrc      = cv[9:8];
            ALUControlD = alu_raw;
            IllegalD    = illegal;
            // A flushed instruction may still decode but must not change architectural state.
            if (!FlushD) begin
                FlagWriteD = flag_raw;
                RegWriteD  = cv[CV_REGWRITE];
                MemWriteD  = cv[CV_MEMWRITE];
                BranchD    = cv[CV_BRANCH];
                Ctrl       = ctrl_raw;
            end
            PCSrcD = ((Rd == 5'd15) && RegWriteD) || BranchD;
        end
    end

    decode_beat_fsm #(
        .BEAT_W(BEAT_W)
    ) u_beat_fsm (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(InstrValidD),
        .hold       (HoldD),
        .flush      (FlushD),
        .n_beats    (n_beats),
        .beat_idx   (BeatIdx),
        .stall      (StallD),
        .last_beat  (LastBeatD)
    );

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: directed scenarios plus randomized
// instruction/hold/flush traffic against a behavioural reference model.
module tb_decoder_seq;

    localparam int KB = 9;
    localparam int PB = 4;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          InstrValidD, HoldD, FlushD;
    logic [2:0]    Op;
    logic [5:0]    Funct;
    logic [4:0]    Rd;
    logic [1:0]    FlagWriteD;
    logic          PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD;
    logic [1:0]    ImmSrcD, RegSrc;
    logic [3:0]    ALUControlD;
    logic [6:0]    Ctrl;
    logic [BW-1:0] BeatIdx;
    logic          LastBeatD, StallD, IllegalD;

    int total = 0;
    int bad   = 0;
    int mbeat = 0;

    decoder_seq #(.KERNEL_BEATS(KB), .PIXEL_BEATS(PB)) dut (
        .clk(clk), .reset(reset), .InstrValidD(InstrValidD), .HoldD(HoldD), .FlushD(FlushD),
        .Op(Op), .Funct(Funct), .Rd(Rd),
        .FlagWriteD(FlagWriteD), .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ImmSrcD(ImmSrcD),
        .RegSrc(RegSrc), .ALUControlD(ALUControlD), .Ctrl(Ctrl), .BeatIdx(BeatIdx),
        .LastBeatD(LastBeatD), .StallD(StallD), .IllegalD(IllegalD)
    );

    always #5 clk = ~clk;

    wire [23:0] act_dec = {FlagWriteD, PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD,
                           ImmSrcD, RegSrc, ALUControlD, Ctrl, IllegalD};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected decode outputs, packed in the same order as act_dec.
    function automatic logic [23:0] exp_dec(input logic v, input logic fl, input logic [2:0] op,
                                            input logic [5:0] f, input logic [4:0] rd);
        logic [9:0] cv;
        logic [6:0] ct;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       ill, pc;
        cv = '0; ct = '0; alu = 4'd3; fw = '0; ill = 1'b0;
        case (op)
            3'd0: cv = f[5] ? 10'b0000101001 : 10'b0000001001;
            3'd1: cv = f[0] ? 10'b0001111000 : 10'b1001110100;
            3'd2: cv = 10'b0010100010;
            3'd4: begin cv = 10'b0000011001; ct = f[0] ? 7'b1101010 : 7'b1100010; end
            3'd5: begin cv = 10'b1000100101; ct = 7'b0100001; end
            3'd6: begin cv = 10'b0000011001; ct = 7'b1001110; end
            default: ill = 1'b1;
        endcase
        if (cv[0]) begin
            case (f[4:1])
                4'd0:  alu = 4'b0000;
                4'd1:  alu = 4'b0110;
                4'd2:  alu = 4'b0010;
                4'd3:  alu = 4'b0111;
                4'd4:  alu = 4'b0011;
                4'd12: alu = 4'b0101;
                4'd13: alu = 4'b0001;
                4'd15: alu = 4'b0100;
                default: ill = 1'b1;
            endcase
            fw = {f[0], f[0] & ((alu == 4'b0011) || (alu == 4'b0010))};
        end
        if (ill) begin cv = '0; ct = '0; alu = '0; fw = '0; end
        if (!v) return '0;
        if (fl) begin cv[3] = 1'b0; cv[2] = 1'b0; cv[1] = 1'b0; fw = '0; ct = '0; end
        pc = ((rd == 5'd15) && cv[3]) || cv[1];
        return {fw, pc, cv[3], cv[2], cv[4], cv[5], cv[1], cv[7:6], cv[9:8], alu, ct, ill};
    endfunction

    function automatic int n_of(input logic [2:0] op, input logic [5:0] f);
        logic [23:0] d;
        d = exp_dec(1'b1, 1'b0, op, f, 5'd0);
        if (d[0]) return 1;
        if (op == 3'd4) return KB;
        if (op == 3'd5 || op == 3'd6) return PB;
        return 1;
    endfunction

    task automatic sample(input string tag);
        int  n;
        logic es, el;
        @(negedge clk);
        n  = n_of(Op, Funct);
        es = InstrValidD && (n > 1) && (mbeat != n - 1) && !FlushD && !reset;
        el = InstrValidD && (mbeat == n - 1);
        chk({tag, ".dec"},   32'(act_dec), 32'(exp_dec(InstrValidD, FlushD, Op, Funct, Rd)));
        chk({tag, ".beat"},  32'(BeatIdx), 32'(mbeat));
        chk({tag, ".stall"}, 32'(StallD),  32'(es));
        chk({tag, ".last"},  32'(LastBeatD), 32'(el));
    endtask

    task automatic adv();
        int n;
        @(posedge clk);
        n = n_of(Op, Funct);
        if (reset || FlushD) mbeat = 0;
        else if (!HoldD && (mbeat != 0 || (InstrValidD && n > 1))) mbeat = (mbeat + 1) % n;
        #1;
    endtask

    initial begin
        reset = 1'b1; InstrValidD = 1'b0; HoldD = 1'b0; FlushD = 1'b0;
        Op = '0; Funct = '0; Rd = '0;
        @(negedge clk);
        chk("rst.beat",  32'(BeatIdx), 32'd0);
        chk("rst.stall", 32'(StallD),  32'd0);
        reset = 1'b0;
        adv();

        // Single-beat data-processing instruction.
        InstrValidD = 1'b1; Op = 3'b000; Funct = 6'b001000; Rd = 5'd3;
        sample("dp");
        chk("dp.alu",  32'(ALUControlD), 32'b0011);
        chk("dp.rw",   32'(RegWriteD), 32'd1);
        chk("dp.fw",   32'(FlagWriteD), 32'd0);
        chk("dp.last", 32'(LastBeatD), 32'd1);
        chk("dp.stl",  32'(StallD), 32'd0);
        adv();

        // Kernel read: nine beats.
        Op = 3'b100; Funct = 6'b000001; Rd = 5'd2;
        for (int i = 0; i < KB; i++) begin
            sample("krd");
            chk("krd.beat", 32'(BeatIdx), 32'(i));
            chk("krd.stl",  32'(StallD), 32'(i < KB - 1));
            chk("krd.ctrl", 32'(Ctrl), 32'b1101010);
            chk("krd.last", 32'(LastBeatD), 32'(i == KB - 1));
            adv();
        end
        InstrValidD = 1'b0;
        sample("gap");
        adv();

        // Picture store with a two-cycle hold at beat 1.
        InstrValidD = 1'b1; Op = 3'b110; Funct = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            int expb [6] = '{0, 1, 1, 1, 2, 3};
            HoldD = (i == 1 || i == 2);
            sample("pst");
            chk("pst.beat", 32'(BeatIdx), 32'(expb[i]));
            chk("pst.stl",  32'(StallD), 32'(i < 5));
            adv();
        end
        HoldD = 1'b0; InstrValidD = 1'b0;
        sample("gap2");
        adv();

        // Pixel read flushed at beat 2.
        InstrValidD = 1'b1; Op = 3'b101; Funct = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            FlushD = (i == 2);
            sample("prd");
            chk("prd.mw", 32'(MemWriteD), 32'(i != 2));
            adv();
        end
        FlushD = 1'b0; InstrValidD = 1'b0;
        sample("prd.after");
        chk("prd.idle", 32'(BeatIdx), 32'd0);
        adv();

        // Illegal encodings.
        InstrValidD = 1'b1; Op = 3'b111; Funct = 6'b111111; Rd = 5'd15;
        sample("ill.op");
        chk("ill.op.flag", 32'(IllegalD), 32'd1);
        chk("ill.op.we",   32'({RegWriteD, MemWriteD}), 32'd0);
        adv();
        Op = 3'b000; Funct = 6'b010100;
        sample("ill.fn");
        chk("ill.fn.flag", 32'(IllegalD), 32'd1);
        chk("ill.fn.we",   32'({RegWriteD, MemWriteD}), 32'd0);
        adv();

        // Reset in the middle of a kernel read, then restart.
        Op = 3'b100; Funct = 6'b001000; Rd = 5'd1;
        for (int i = 0; i < 5; i++) begin sample("krd2"); adv(); end
        chk("krd2.at5", 32'(BeatIdx), 32'd5);
        reset = 1'b1;
        #1;
        chk("rstmid.stall", 32'(StallD),  32'd0);
        chk("rstmid.beat",  32'(BeatIdx), 32'd0);
        mbeat = 0;
        #2 reset = 1'b0;
        for (int i = 0; i < KB; i++) begin
            sample("krd3");
            chk("krd3.beat", 32'(BeatIdx), 32'(i));
            adv();
        end

        // Randomized traffic; a new instruction only appears when no sequence is in flight.
        for (int i = 0; i < 400; i++) begin
            if (mbeat == 0) begin
                InstrValidD = ($urandom_range(0, 3) != 0);
                Op    = 3'($urandom);
                Funct = 6'($urandom);
                Rd    = 5'($urandom);
            end
            HoldD  = ($urandom_range(0, 4) == 0);
            FlushD = ($urandom_range(0, 19) == 0);
            sample("rand");
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Parametrised successor to the pipeline's instruction decoder. Decodes the 3-bit opcode class and 6-bit Funct field into datapath controls, as the single-cycle decoder does. It also expands the image-processing memory instructions (kernel read, pixel read, picture store) into multi-beat micro-op sequences. While a sequence runs it stalls fetch/decode, so one instruction moves a whole kernel or pixel vector. Sits in the Decode stage, between the IF/ID register and the ID/EX register, alongside the hazard unit.

## Interface
Parameters:
- KERNEL_BEATS, 9, words per kernel-read instruction (3x3 kernel); ≥1
- PIXEL_BEATS, 4, words per pixel-read or picture-store instruction (lane count); ≥1
- BEAT_W, $clog2(max(KERNEL_BEATS,PIXEL_BEATS)+1), beat index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock
- InstrValidD  in  1  Op/Funct/Rd hold a valid instruction
- HoldD  in  1  hazard-unit stall; freezes beat counter and state
- FlushD  in  1  branch flush; aborts any sequence
- Op  in  3  opcode class
- Funct  in  6  function field
- Rd  in  5  destination register
- FlagWriteD, PCSrcD, RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD  out  2/1/1/1/1/1/1  datapath controls
- ImmSrcD, RegSrc  out  2, 2  immediate/register source selects
- ALUControlD  out  4  ALU operation
- Ctrl  out  7  memory-section control
- BeatIdx  out  BEAT_W  current beat (0-based), address offset for memory stage
- LastBeatD  out  1  current beat is final (single-beat instructions: always 1 when valid)
- StallD  out  1  hold PC and IF/ID register
- IllegalD  out  1  valid instruction with undefined Op or ALU Funct

## Operation
- Control vector {RegSrc,ImmSrc,ALUSrc,MemtoReg,RegWrite,MemWrite,Branch,ALUOp}:
  - Op 000: 0000101001 if Funct[5], else 0000001001.
  - Op 001: 0001111000 if Funct[0] (load), else 1001110100.
  - Op 010: 0010100010.
  - Op 100: 0000011001.
  - Op 101: 1000100101.
  - Op 110: 0000011001.
- Undefined Op (011, 111): all controls 0, IllegalD=1. No X outputs ever.
- Ctrl: Op100 → 1101010 if Funct[0], else 1100010; Op101 → 0100001; Op110 → 1001110; otherwise 0.
- ALUOp=1: Funct[4:1] maps to ALUControlD as follows: 0000→0000 vsum, 0001→0110 mul, 0010→0010 sub, 0011→0111 concat, 0100→0011 add, 1100→0101 scale, 1101→0001 dot, 1111→0100 cmp.
  - Other Funct[4:1] values: ALUControlD=0000, controls zeroed, IllegalD=1.
  - FlagWriteD[1]=Funct[0]; FlagWriteD[0]=Funct[0] & (ALU is add or sub).
- ALUOp=0: ALUControlD=0011, FlagWriteD=00.
- PCSrcD = (Rd==15 & RegWriteD) | BranchD.
- Beat count N: Op100 → KERNEL_BEATS; Op101, Op110 → PIXEL_BEATS; all others 1.
- FSM states:
  - IDLE → SEQ when InstrValidD & N>1 & !HoldD & !FlushD.
  - SEQ → IDLE after beat N-1 advances.
  - FlushD in any state → IDLE.
- Controls are decoded from Op/Funct/Rd, which IF/ID holds stable while StallD=1. Identical controls on every beat; only BeatIdx changes.

## Timing
- Reset values: state IDLE, BeatIdx=0, StallD=0. Decode outputs follow inputs combinationally, gated to 0 when InstrValidD=0.
- Decode path is combinational, zero latency. Beat state is registered.
- N-beat instruction presented at cycle 0: BeatIdx=0..N-1 over cycles 0..N-1. StallD=1 on cycles 0..N-2, 0 on cycle N-1. LastBeatD=1 only on cycle N-1.
- HoldD=1: BeatIdx, state and StallD held. Outputs repeat the current beat.
- FlushD=1: RegWriteD, MemWriteD, PCSrcD, FlagWriteD, BranchD and Ctrl forced 0 that cycle. StallD=0; IDLE and BeatIdx=0 next edge.
- FlushD and HoldD together: flush wins.
- Reset mid-sequence: immediate IDLE, BeatIdx=0, StallD=0.
- KERNEL_BEATS=1 or PIXEL_BEATS=1: that op is single-beat, never enters SEQ.

## Structure
- Package decoder_pkg: opcode constants, ALUControl codes, 10-bit control-vector constants, Ctrl constants, beat_state_t enum {IDLE, SEQ}.
- Sub-module decode_beat_fsm: state register, beat counter, StallD/LastBeatD. The top holds the combinational decode tables.

## Test plan
- Op000, Funct=001000, Rd=3, valid → ALUControlD=0011, RegWriteD=1, FlagWriteD=00, LastBeatD=1, StallD=0.
- Op100, Funct[0]=1, defaults → BeatIdx 0..8 over 9 cycles, StallD high 8 cycles, Ctrl=1101010 throughout, LastBeatD on cycle 8.
- Op110 with HoldD pulsed for 2 cycles at beat 1 → BeatIdx sequence 0,1,1,1,2,3; StallD drops with BeatIdx=3.
- Op101 with FlushD at beat 2 → MemWriteD=0 that cycle, IDLE next cycle, BeatIdx=0.
- Op111, or Op000 with Funct[4:1]=1010 → IllegalD=1, all write enables 0, no X.
- reset asserted at beat 5 of kernel read → StallD=0 and BeatIdx=0 immediately; next Op100 restarts at beat 0.
